// File: rtl/compressor_sequencer.sv
// compressor_sequencer
//   Transactional loader for the operand-compression datapath. It accepts NUM
//   operands one per cycle over a valid/ready stream and writes them, in slot
//   order, into the operand registers that feed the compressor. It then waits
//   SETTLE cycles, captures the compressor result and offers it downstream on
//   a valid/ready output.
//
//   Optional feature macro: COMPRESSOR_SEQ_CHECK_EN
//     defined   - a behavioural adder sums the cmp_src slots. Every capture
//                 compares that sum with cmp_dst. Any inequality sets the
//                 sticky 'mismatch' flag, which only rst clears.
//     undefined - no adder is built and 'mismatch' is tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous abort of a partial load or of a held result
//   in_data    operand, in_valid / in_ready handshake
//   cmp_src    registered operand vector; slot k at [k*WIDTH +: WIDTH]
//   cmp_dst    compressor result (combinational or SETTLE-pipelined)
//   out_data   captured result, out_valid / out_ready handshake
//   busy       high unless idle in LOAD with no operand loaded
//   mismatch   sticky self-check error (see macro above)
module compressor_sequencer #(
  parameter int WIDTH  = 8,
  parameter int NUM    = 8,
  parameter int SETTLE = 1,
  localparam int OUT_WIDTH = WIDTH + $clog2(NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM*WIDTH-1:0]   cmp_src,
  input  logic [OUT_WIDTH-1:0]   cmp_dst,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   mismatch
);

  localparam int IDX_W = $clog2(NUM);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic             ready_q;
  logic             accept;
  logic             capture;
  logic             last_slot;

  // ready_q keeps in_ready low during reset and for the rest of the reset
  // cycle; it rises on the first edge after rst is released.
  assign in_ready  = ready_q && (state == S_LOAD);
  assign out_valid = (state == S_HOLD);
  assign busy      = !((state == S_LOAD) && (idx == '0));
  assign last_slot = (idx == IDX_W'(NUM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_next;
  end

  // clear overrides every transition and suppresses the operand accept and
  // the result capture that would otherwise happen on the same edge.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_LOAD: begin
        accept = in_valid && in_ready;
        if (accept && last_slot) state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (count == CNT_W'(SETTLE - 1)) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_next = S_LOAD;
      end
      default: state_next = S_LOAD;
    endcase
    if (clear) begin
      state_next = S_LOAD;
      accept     = 1'b0;
      capture    = 1'b0;
    end
  end

  // Operand slots are never zeroed between transactions: each load simply
  // overwrites slots 0..NUM-1 in order. clear leaves cmp_src and out_data as
  // they are and only rewinds the slot index and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b0;
      idx      <= '0;
      count    <= '0;
      cmp_src  <= '0;
      out_data <= '0;
    end else begin
      ready_q <= 1'b1;
      if (clear) begin
        idx   <= '0;
        count <= '0;
      end else begin
        if (accept) begin
          cmp_src[idx*WIDTH +: WIDTH] <= in_data;
          idx   <= last_slot ? '0 : idx + 1'b1;
          count <= '0;
        end
        if (capture) begin
          out_data <= cmp_dst;
          count    <= '0;
        end else if (state == S_SETTLE) begin
          count <= count + 1'b1;
        end
      end
    end
  end

`ifdef COMPRESSOR_SEQ_CHECK_EN
  logic [OUT_WIDTH-1:0] ref_sum;

  // Reference compressor: zero-extended unsigned sum of all slots.
  always_comb begin
    ref_sum = '0;
    for (int k = 0; k < NUM; k++) begin
      ref_sum = ref_sum + OUT_WIDTH'(cmp_src[k*WIDTH +: WIDTH]);
    end
  end

  // Sticky until rst; clear deliberately leaves it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               mismatch <= 1'b0;
    else if (capture && ref_sum != cmp_dst) mismatch <= 1'b1;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_compressor_sequencer.sv
// tb_compressor_sequencer
//   Self-checking bench for compressor_sequencer at default parameters
//   (WIDTH=8, NUM=8, SETTLE=1). A behavioural compressor drives cmp_dst from
//   cmp_src. Expected sums are pushed to a scoreboard queue as operands are
//   driven and popped when the DUT presents a result.
module tb_compressor_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] cmp_src;
  logic [10:0] cmp_dst;
  logic [10:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        mismatch;

  int          checks   = 0;
  int          failures = 0;
  logic [10:0] scoreboard[$];
  logic [63:0] exp_src  = '0;
  int          model_idx = 0;
  bit          force_zero = 1'b0;
  logic [10:0] held;

  always #5 clk = ~clk;

  compressor_sequencer dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmp_src(cmp_src), .cmp_dst(cmp_dst),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .mismatch(mismatch)
  );

  // Behavioural combinational compressor; force_zero models a broken one.
  always_comb begin
    cmp_dst = '0;
    for (int k = 0; k < 8; k++) cmp_dst = cmp_dst + 11'(cmp_src[k*8 +: 8]);
    if (force_zero) cmp_dst = '0;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive and sample 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  // Offer one operand and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [7:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput("accept_wait", 64'(guard < 100), 64'd1);
    tick();
    in_valid = 1'b0;
    exp_src[model_idx*8 +: 8] = d;
    model_idx = (model_idx + 1) % 8;
  endtask

  task automatic loadPattern(input logic [7:0] base, input logic [7:0] step,
                             input int count, input bit expect_result);
    logic [10:0] sum;
    logic [7:0]  v;
    sum = '0;
    for (int i = 0; i < count; i++) begin
      v = base + 8'(i) * step;
      applyStimulus(v);
      sum = sum + 11'(v);
    end
    if (expect_result) scoreboard.push_back(force_zero ? 11'd0 : sum);
  endtask

  // Called right after the last accept edge: the result must appear after
  // exactly SETTLE (=1) more edges. With out_ready high the handshake then
  // completes on the following edge.
  task automatic collectResult(input string tag, output logic [10:0] value);
    int waited = 0;
    logic [10:0] exp_val;
    checkOutput({tag, "_src"}, cmp_src, exp_src);
    while (!out_valid && waited < 100) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_latency"}, 64'(waited), 64'd1);
    exp_val = 11'h7FF;
    if (scoreboard.size() > 0) exp_val = scoreboard.pop_front();
    checkOutput({tag, "_data"}, out_data, exp_val);
    value = out_data;
    if (out_ready) begin
      tick();
      checkOutput({tag, "_valid_1cyc"}, out_valid, 1'b0);
      checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_in_ready",  in_ready,  1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data",  out_data,  11'd0);
    checkOutput("rst_cmp_src",   cmp_src,   64'd0);
    checkOutput("rst_busy",      busy,      1'b0);
    checkOutput("rst_mismatch",  mismatch,  1'b0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready_low", in_ready, 1'b0);
    tick();
    checkOutput("post_rst_ready_high", in_ready, 1'b1);

    // 0x01..0x08 back to back -> 0x024
    loadPattern(8'h01, 8'h01, 8, 1'b1);
    checkOutput("seq_in_ready_settle", in_ready, 1'b0);
    checkOutput("seq_busy_settle", busy, 1'b1);
    collectResult("seq", held);

    // all 0xFF -> 0x7F8, then all 0x00 -> 0x000 (every slot overwritten)
    loadPattern(8'hFF, 8'h00, 8, 1'b1);
    collectResult("ff", held);
    loadPattern(8'h00, 8'h00, 8, 1'b1);
    collectResult("zero", held);

    // out_ready low in HOLD for 5 cycles while operands are offered
    out_ready = 1'b0;
    loadPattern(8'h03, 8'h05, 8, 1'b1);
    collectResult("stall", held);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", out_valid, 1'b1);
      checkOutput("stall_data", out_data, held);
      checkOutput("stall_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    checkOutput("stall_src_kept", cmp_src, exp_src);
    out_ready = 1'b1;
    tick();
    checkOutput("release_valid", out_valid, 1'b0);
    checkOutput("release_in_ready", in_ready, 1'b1);

    // partial load of 4, clear with a simultaneous offer, then 8 x 0x10
    loadPattern(8'h20, 8'h01, 4, 1'b0);
    checkOutput("partial_busy", busy, 1'b1);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    model_idx = 0;
    checkOutput("clear_busy", busy, 1'b0);
    checkOutput("clear_in_ready", in_ready, 1'b1);
    checkOutput("clear_src_kept", cmp_src, exp_src);
    loadPattern(8'h10, 8'h00, 8, 1'b1);
    collectResult("after_clear", held);

    // asynchronous reset during SETTLE
    loadPattern(8'h11, 8'h07, 8, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_out_valid", out_valid, 1'b0);
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_in_ready", in_ready, 1'b0);
    checkOutput("rst_mid_out_data", out_data, 11'd0);
    exp_src = '0;
    model_idx = 0;
    tick();
    rst = 1'b0;
    tick();
    loadPattern(8'h07, 8'h09, 8, 1'b1);
    collectResult("after_rst", held);

`ifdef COMPRESSOR_SEQ_CHECK_EN
    force_zero = 1'b1;
    loadPattern(8'h01, 8'h01, 8, 1'b1);
    collectResult("chk_bad", held);
    checkOutput("chk_mismatch_set", mismatch, 1'b1);
    force_zero = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_idx = 0;
    checkOutput("chk_mismatch_after_clear", mismatch, 1'b1);
    loadPattern(8'h02, 8'h03, 8, 1'b1);
    collectResult("chk_good", held);
    checkOutput("chk_mismatch_sticky", mismatch, 1'b1);
`else
    checkOutput("mismatch_tied_low", mismatch, 1'b0);
`endif

    checkOutput("scoreboard_empty", 64'(scoreboard.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
